// File: rtl/sin_pwm_dac.sv
// Frame-based PWM DAC for signed sine samples.
// A one-deep holding register feeds a new duty value at each frame boundary.
module sin_pwm_dac #(
  parameter int WIDTH    = 9,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             underrun,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] MID  =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hvld_q, hvld_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             pwm_q, pwm_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             last;
  logic             active;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] duty_eff;

  always_comb begin
    tick     = (presc_q == PMAX);
    last     = tick && (cnt_q == CMAX);
    active   = (state_q != IDLE);
    load     = (state_q == RUN) &&
               (cnt_q == '0) && (presc_q == '0);
    xfer     = sample_valid && !hvld_q;
    duty_eff = (load && hvld_q) ? hold_q : duty_q;

    state_d  = state_q;
    hold_d   = hold_q;
    hvld_d   = hvld_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    fs_d     = 1'b0;
    ur_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = last ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (en)        state_d = RUN;
        else if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      duty_d = duty_eff;
      fs_d   = 1'b1;
      ur_d   = !hvld_q;
      hvld_d = 1'b0;
    end

    // Offset binary: flipping the sign bit maps -2^(W-1) to zero duty.
    if (xfer) begin
      hold_d = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
      hvld_d = 1'b1;
    end

    if (state_d == IDLE) begin
      cnt_d   = '0;
      presc_d = '0;
    end else if (active) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) cnt_d = cnt_q + 1'b1;
    end

    pwm_d  = active && (cnt_q < duty_eff);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      hvld_q  <= 1'b0;
      duty_q  <= MID;
      cnt_q   <= '0;
      presc_q <= '0;
      pwm_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      busy_q  <= busy_d;
    end
  end

  assign sample_ready = !hvld_q;
  assign pwm_out      = pwm_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sin_pwm_dac.sv
// Scoreboard bench for sin_pwm_dac: stimulus queues expected frames,
// a per-frame monitor measures length, high time and underrun.
module tb_sin_pwm_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, en0, vld0, rdy0, pwm0, fs0, ur0, busy0;
  logic [8:0] smp0;
  logic       rst3_n, en3, vld3, rdy3, pwm3, fs3, ur3, busy3;
  logic [8:0] smp3;

  sin_pwm_dac #(.WIDTH(9), .PRESCALE(1)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .en(en0),
    .sample_in(smp0), .sample_valid(vld0),
    .sample_ready(rdy0), .pwm_out(pwm0),
    .frame_start(fs0), .underrun(ur0), .busy(busy0)
  );

  sin_pwm_dac #(.WIDTH(9), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .en(en3),
    .sample_in(smp3), .sample_valid(vld3),
    .sample_ready(rdy3), .pwm_out(pwm3),
    .frame_start(fs3), .underrun(ur3), .busy(busy3)
  );

  typedef struct {
    int len;
    int hi;
    int ur;
  } frame_t;

  frame_t exp0[$];
  frame_t exp3[$];
  int n_chk = 0;
  int n_fail = 0;

  int  m_len[2], m_tot[2], m_lead[2], m_ur[2];
  bit  m_in[2], m_open[2];

  function automatic frame_t mk(input int l, input int h, input int u);
    frame_t f;
    f.len = l; f.hi = h; f.ur = u;
    return f;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic finish_frame(input int d);
    frame_t e;
    m_in[d] = 1'b0;
    if ((d == 0) ? (exp0.size() == 0) : (exp3.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d unexpected frame: len %0d high %0d, expected none",
               d, m_len[d], m_tot[d]);
      return;
    end
    e = (d == 0) ? exp0.pop_front() : exp3.pop_front();
    chk($sformatf("dut%0d frame len", d), m_len[d], e.len);
    chk($sformatf("dut%0d frame high", d), m_tot[d], e.hi);
    chk($sformatf("dut%0d frame lead high", d), m_lead[d], e.hi);
    chk($sformatf("dut%0d frame underrun", d), m_ur[d], e.ur);
  endtask

  task automatic mon(input int d, input logic rst, input logic fs,
                     input logic pwm, input logic bsy, input logic ur);
    if (!rst) begin
      m_in[d] = 1'b0;
      return;
    end
    if (fs) begin
      if (m_in[d]) finish_frame(d);
      m_in[d]   = 1'b1;
      m_len[d]  = 1;
      m_tot[d]  = int'(pwm);
      m_lead[d] = int'(pwm);
      m_open[d] = pwm;
      m_ur[d]   = int'(ur);
      if (!bsy) finish_frame(d);
    end else if (m_in[d]) begin
      m_len[d]++;
      if (pwm) begin
        m_tot[d]++;
        if (m_open[d]) m_lead[d]++;
      end else begin
        m_open[d] = 1'b0;
      end
      chk($sformatf("dut%0d underrun mid-frame", d), int'(ur), 0);
      if (!bsy) finish_frame(d);
    end else begin
      chk($sformatf("dut%0d pwm outside frame", d), int'(pwm), 0);
      chk($sformatf("dut%0d underrun outside frame", d), int'(ur), 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0_n, fs0, pwm0, busy0, ur0);
    mon(1, rst3_n, fs3, pwm3, busy3, ur3);
  end

  task automatic send(input int d, input logic [8:0] s, output int waited);
    bit done = 1'b0;
    waited = 0;
    if (d == 0) begin smp0 = s; vld0 = 1'b1; end
    else        begin smp3 = s; vld3 = 1'b1; end
    for (int n = 0; n < 5000 && !done; n++) begin
      done = (d == 0) ? rdy0 : rdy3;
      @(negedge clk);
      if (!done) waited++;
    end
    if (d == 0) vld0 = 1'b0;
    else        vld3 = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d send timeout: ready 0, expected 1", d);
    end
  endtask

  // which: 0 ur0 high, 1 busy0 low, 2 busy3 low, 3 rdy3 high
  task automatic wait_sig(input string name, input int which, input int lim);
    bit met = 1'b0;
    for (int n = 0; n < lim && !met; n++) begin
      @(negedge clk);
      unique case (which)
        0: met = ur0;
        1: met = !busy0;
        2: met = !busy3;
        default: met = rdy3;
      endcase
    end
    chk(name, int'(met), 1);
  endtask

  task automatic chk_rst(input int d, input logic p, input logic b,
                         input logic r, input logic f, input logic u);
    chk($sformatf("dut%0d reset pwm", d), int'(p), 0);
    chk($sformatf("dut%0d reset busy", d), int'(b), 0);
    chk($sformatf("dut%0d reset ready", d), int'(r), 1);
    chk($sformatf("dut%0d reset frame_start", d), int'(f), 0);
    chk($sformatf("dut%0d reset underrun", d), int'(u), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst0_n = 1'b1; rst3_n = 1'b1;
    en0 = 1'b0; vld0 = 1'b0; smp0 = '0;
    en3 = 1'b0; vld3 = 1'b0; smp3 = '0;
    #1;
    rst0_n = 1'b0; rst3_n = 1'b0;
    #3;
    chk_rst(0, pwm0, busy0, rdy0, fs0, ur0);
    chk_rst(1, pwm3, busy3, rdy3, fs3, ur3);
    @(negedge clk); #2;
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // PRESCALE=1: mid, zero, full, 3/4, then an underrun repeat
    send(0, 9'h000, w);
    exp0.push_back(mk(512, 256, 0));
    en0 = 1'b1;
    exp0.push_back(mk(512, 0, 0));
    send(0, 9'h100, w);
    exp0.push_back(mk(512, 511, 0));
    send(0, 9'h0FF, w);
    exp0.push_back(mk(512, 384, 0));
    send(0, 9'h080, w);
    exp0.push_back(mk(512, 384, 1));
    wait_sig("dut0 underrun frame seen", 0, 3000);
    repeat (99) @(negedge clk);
    en0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("dut0 busy during drain", int'(busy0), 1);
    wait_sig("dut0 drain completes", 1, 1000);
    @(negedge clk);
    chk("dut0 pwm after drain", int'(pwm0), 0);
    chk("dut0 busy after drain", int'(busy0), 0);
    repeat (50) @(negedge clk);

    // restart, fill hold, then reset mid-frame: hold must be discarded
    en0 = 1'b1;
    repeat (200) @(negedge clk);
    chk("dut0 pwm high before reset", int'(pwm0), 1);
    send(0, 9'h19C, w);
    chk("dut0 ready with hold full", int'(rdy0), 0);
    repeat (10) @(negedge clk);
    #2;
    rst0_n = 1'b0;
    en0 = 1'b0;
    #1;
    chk_rst(0, pwm0, busy0, rdy0, fs0, ur0);
    @(negedge clk); #2;
    rst0_n = 1'b1;
    @(negedge clk);
    exp0.push_back(mk(512, 256, 1));
    en0 = 1'b1;
    repeat (3) @(negedge clk);
    en0 = 1'b0;
    wait_sig("dut0 post-reset drain", 1, 1000);
    repeat (3) @(negedge clk);

    // PRESCALE=3 with a producer stalled on a full hold register
    send(1, 9'h080, w);
    exp3.push_back(mk(1536, 1152, 0));
    en3 = 1'b1;
    exp3.push_back(mk(1536, 768, 0));
    send(1, 9'h000, w);
    chk("dut3 ready with hold full", int'(rdy3), 0);
    exp3.push_back(mk(1536, 384, 0));
    send(1, 9'h180, w);
    chk("dut3 producer stalled until load", int'(w > 1400), 1);
    wait_sig("dut3 third frame loads", 3, 2000);
    en3 = 1'b0;
    wait_sig("dut3 drain completes", 2, 2000);
    repeat (3) @(negedge clk);
    chk("dut3 pwm after drain", int'(pwm3), 0);

    chk("dut0 frames outstanding", exp0.size(), 0);
    chk("dut3 frames outstanding", exp3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
